// File: rtl/rv_pkg.sv
// rv_pkg: core-wide datapath constants and the register-dump FSM state type.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams registers FIRST_REG..LAST_REG out over a valid/ready port,
// borrowing the shared register-file read port through a req/gnt handshake.
module reg_dump_reader
  import rv_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  portReq,
  input  logic                  portGnt,
  output logic [REG_ADDR_W-1:0] rdAddr,
  input  logic [XLEN-1:0]       rdData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [XLEN-1:0]       outData,
  output logic [REG_ADDR_W-1:0] outIndex,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);
  localparam logic [REG_ADDR_W-1:0] FIRST = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST  = REG_ADDR_W'(LAST_REG);
  dump_state_t           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d, oidx_q, oidx_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  last_q, last_d;
  logic                  grab, accept;
  assign grab   = state_q == ST_READ && portGnt;
  assign accept = state_q == ST_SEND && outReady;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_REQ : ST_IDLE;
      ST_REQ:  state_d = portGnt ? ST_READ : ST_REQ;
      ST_READ: state_d = portGnt ? ST_SEND : ST_REQ;
      ST_SEND: state_d = outReady ? (last_q ? ST_DONE : ST_READ) : ST_SEND;
      default: state_d = ST_IDLE;
    endcase
  end
  // The counter only advances on a non-last accept, so it can never wrap past LAST.
  always_comb begin
    idx_d  = state_q == ST_IDLE && start ? FIRST :
             accept && !last_q ? idx_q + 1'b1 : idx_q;
    data_d = grab ? rdData : data_q;
    oidx_d = grab ? idx_q : oidx_q;
    last_d = grab ? idx_q == LAST : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      oidx_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign portReq  = state_q == ST_REQ || state_q == ST_READ;
  assign rdAddr   = state_q == ST_READ ? idx_q : '0;
  assign outValid = state_q == ST_SEND;
  assign outData  = data_q;
  assign outIndex = oidx_q;
  assign outLast  = last_q;
  assign busy     = state_q != ST_IDLE;
  assign done     = state_q == ST_DONE;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench; expected beats are queued at start, a monitor pops on each accepted beat.
module tb_reg_dump_reader;
  logic        clk = 0, rst_n = 0, start = 0, portGnt = 0, outReady = 0;
  logic        portReq, outValid, outLast, busy, done;
  logic [4:0]  rdAddr, outIndex;
  logic [31:0] rdData, outData;
  logic        s_start = 0, s_portGnt = 1, s_outReady = 1;
  logic        s_portReq, s_outValid, s_outLast, s_busy, s_done;
  logic [4:0]  s_rdAddr, s_outIndex;
  logic [31:0] s_rdData, s_outData;
  logic [31:0] regs [32];
  int          checks = 0, passed = 0, dones = 0;
  logic        rnd = 0;
  typedef struct {logic [4:0] idx; logic [31:0] data; logic last;} beat_t;
  beat_t       exp_q [$];
  beat_t       e;
  logic        hold_v = 0;
  logic [31:0] hold_d;
  logic [4:0]  hold_i;

  always #5 clk = ~clk;
  assign rdData   = regs[rdAddr];
  assign s_rdData = regs[s_rdAddr];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .portReq(portReq), .portGnt(portGnt),
    .rdAddr(rdAddr), .rdData(rdData), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outIndex(outIndex), .outLast(outLast), .busy(busy), .done(done)
  );

  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(s_start), .portReq(s_portReq), .portGnt(s_portGnt),
    .rdAddr(s_rdAddr), .rdData(s_rdData), .outValid(s_outValid), .outReady(s_outReady),
    .outData(s_outData), .outIndex(s_outIndex), .outLast(s_outLast), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for a default-parameter dump: every index 0..31 in order, data as the register file holds it.
  task automatic push_dump(input int patch_idx, input logic [31:0] patch_val);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = (i == patch_idx) ? patch_val : regs[i];
      b.last = (i == 31);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_beat(input logic [4:0] idx);
    int n = 0;
    while (!(outValid && outIndex == idx) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_beat", {27'd0, outIndex}, {27'd0, idx});
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rnd) begin
      portGnt  = ($urandom % 4) != 0;
      outReady = ($urandom % 3) != 0;
    end
  end

  always @(negedge clk) begin
    if (done) dones++;
    if (!portReq) chk("rdaddr_idle", {27'd0, rdAddr}, 0);
    if (outValid) begin
      if (hold_v) begin
        chk("hold_data", outData, hold_d);
        chk("hold_idx", {27'd0, outIndex}, {27'd0, hold_i});
      end
      if (outReady) begin
        hold_v = 0;
        if (exp_q.size() == 0) chk("unexpected_beat", {27'd0, outIndex}, 32'hffff_ffff);
        else begin
          e = exp_q.pop_front();
          chk("beat_idx", {27'd0, outIndex}, {27'd0, e.idx});
          chk("beat_data", outData, e.data);
          chk("beat_last", {31'd0, outLast}, {31'd0, e.last});
        end
      end else begin
        hold_v = 1;
        hold_d = outData;
        hold_i = outIndex;
      end
    end else hold_v = 0;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_portReq"}, {31'd0, portReq}, 0);
    chk({tag, "_rdAddr"}, {27'd0, rdAddr}, 0);
    chk({tag, "_outValid"}, {31'd0, outValid}, 0);
    chk({tag, "_outData"}, outData, 0);
    chk({tag, "_outIndex"}, {27'd0, outIndex}, 0);
    chk({tag, "_outLast"}, {31'd0, outLast}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    int d0, n;
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1;
    tick();

    // full dump with latency check
    portGnt = 1;
    outReady = 1;
    d0 = dones;
    push_dump(-1, 0);
    pulse_start();
    chk("lat_e1_valid", {31'd0, outValid}, 0);
    chk("lat_e1_busy", {31'd0, busy}, 1);
    tick();
    chk("lat_e2_valid", {31'd0, outValid}, 0);
    tick();
    chk("lat_e3_valid", {31'd0, outValid}, 1);
    wait_done(200);
    chk("full_queue_empty", exp_q.size(), 0);
    chk("full_done_count", dones - d0, 1);

    // backpressure on beat 3
    d0 = dones;
    push_dump(-1, 0);
    pulse_start();
    wait_beat(3);
    outReady = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, outValid}, 1);
      chk("bp_idx", {27'd0, outIndex}, 3);
      chk("bp_data", outData, 32'h1000_0003);
    end
    outReady = 1;
    wait_done(200);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_done_count", dones - d0, 1);

    // grant loss while reading index 10; the register changes before grant returns
    d0 = dones;
    push_dump(10, 32'hCAFE_0010);
    pulse_start();
    n = 0;
    while (rdAddr != 5'd10 && n < 500) begin
      tick();
      n++;
    end
    chk("gl_reach_read10", {27'd0, rdAddr}, 10);
    portGnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) regs[10] = 32'hCAFE_0010;
      chk("gl_portReq", {31'd0, portReq}, 1);
      chk("gl_valid", {31'd0, outValid}, 0);
    end
    portGnt = 1;
    wait_done(200);
    chk("gl_queue_empty", exp_q.size(), 0);
    chk("gl_done_count", dones - d0, 1);

    // start during beat 7 is ignored
    d0 = dones;
    push_dump(-1, 0);
    pulse_start();
    wait_beat(7);
    pulse_start();
    wait_done(200);
    repeat (5) tick();
    chk("ign_busy", {31'd0, busy}, 0);
    chk("ign_queue_empty", exp_q.size(), 0);
    chk("ign_done_count", dones - d0, 1);

    // reset mid-dump at beat 12
    d0 = dones;
    push_dump(-1, 0);
    pulse_start();
    wait_beat(12);
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1;
    repeat (6) tick();
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_valid", {31'd0, outValid}, 0);
    chk("post_rst_done_count", dones - d0, 0);

    // randomized data and handshakes, dump must restart at index 0
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    d0 = dones;
    push_dump(-1, 0);
    rnd = 1;
    pulse_start();
    wait_done(3000);
    rnd = 0;
    tick();
    portGnt = 1;
    outReady = 1;
    repeat (3) tick();
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_done_count", dones - d0, 1);

    // single-register instance FIRST_REG = LAST_REG = 5
    s_start = 1;
    tick();
    s_start = 0;
    n = 0;
    while (!s_outValid && n < 20) begin
      tick();
      n++;
    end
    chk("one_valid", {31'd0, s_outValid}, 1);
    chk("one_idx", {27'd0, s_outIndex}, 5);
    chk("one_last", {31'd0, s_outLast}, 1);
    chk("one_data", s_outData, regs[5]);
    tick();
    chk("one_done", {31'd0, s_done}, 1);
    chk("one_no_second_beat", {31'd0, s_outValid}, 0);
    tick();
    chk("one_done_pulse", {31'd0, s_done}, 0);
    chk("one_idle", {31'd0, s_busy}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, the first register index dumped.
REQ-002 The block SHALL have parameter LAST_REG, default 31, the last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The ports SHALL be as follows, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  dump request, sampled in IDLE only
- portReq  out  1  request for the register-file read port
- portGnt  in  1  read port granted to this block
- rdAddr  out  5  register-file read address
- rdData  in  32  combinational register-file read data
- outValid  out  1  stream beat valid
- outReady  in  1  downstream accepts beat
- outData  out  32  register value
- outIndex  out  5  register index of outData
- outLast  out  1  beat is LAST_REG
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

Function
REQ-005 The FSM SHALL have states IDLE, REQ, READ, SEND and DONE.
REQ-006 IDLE -> REQ SHALL occur on a clock edge with start=1; the index counter loads FIRST_REG.
REQ-007 In REQ and READ, portReq SHALL be 1; in all other states it SHALL be 0.
REQ-008 REQ -> READ SHALL occur on an edge with portGnt=1; otherwise the FSM stays in REQ.
REQ-009 In READ, rdAddr SHALL equal the index counter.
REQ-010 In READ, if portGnt=1, rdData and the index SHALL be captured into outData and outIndex, and the FSM SHALL go to SEND.
REQ-011 In READ, if portGnt=0, the FSM SHALL return to REQ without capturing data.
REQ-012 Outside READ, rdAddr SHALL be 0.
REQ-013 In SEND, outValid SHALL be 1, and outData, outIndex and outLast SHALL be held stable until the beat is accepted (outValid and outReady both 1 on an edge).
REQ-014 outLast SHALL be 1 exactly when outIndex == LAST_REG.
REQ-015 When a SEND beat is accepted and it is not the last beat, the counter SHALL increment by 1 and the FSM SHALL go to READ. Throughput is therefore one beat per 2 cycles with portGnt and outReady held high.
REQ-016 When the last beat is accepted, the FSM SHALL go to DONE.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-018 start asserted outside IDLE SHALL be ignored. It SHALL NOT be queued.
REQ-019 Index x0 SHALL be dumped with the value returned on rdData, which is 0. The block SHALL NOT special-case x0.
REQ-020 The counter SHALL never wrap. With FIRST_REG == LAST_REG, exactly one beat SHALL be produced, with outLast=1.
REQ-021 Latency: start in IDLE with portGnt=1 and outReady=1 SHALL give outValid=1 on the third edge after start is sampled (IDLE->REQ->READ->SEND).
REQ-022 outValid SHALL NOT depend combinationally on outReady.

Reset
REQ-023 While rst_n=0, the FSM SHALL be IDLE and outputs SHALL be: portReq=0, rdAddr=0, outValid=0, outData=0, outIndex=0, outLast=0, busy=0, done=0.
REQ-024 Reset asserted mid-dump SHALL abort immediately. No further beat or done pulse SHALL be produced, and a new start SHALL be required after release.
REQ-025 Reset release SHALL be synchronised by the enclosing design; the block SHALL leave IDLE only on start.

Structure
REQ-026 rv_pkg SHALL hold XLEN=32, REG_ADDR_W=5 and the typedef dump_state_t (enum of the five states). These are shared with the core.
REQ-027 The block SHALL be a single module with no sub-modules. Counter, FSM and output registers are inline.
REQ-028 Arbitration of the register-file read port (core versus portReq) SHALL be outside this block.

Verification
REQ-029 Full dump: registers preloaded x1..x31 = 32'h1000_0000+i; start pulse; portGnt=1, outReady=1. Required: 32 beats, outIndex 0..31, outData 0 then 32'h1000_0001..32'h1000_001F, outLast only on index 31, one done pulse.
REQ-030 Backpressure: outReady=0 for 5 cycles during beat index 3. Required: outData, outIndex and outValid held for all 5 cycles, no beat lost or duplicated.
REQ-031 Grant loss: portGnt dropped for 4 cycles during READ of index 10. Required: return to REQ with portReq=1; beat 10 carries the value present once the grant returns.
REQ-032 Ignored start: start pulsed at beat 7. Required: exactly one dump and one done pulse.
REQ-033 Reset mid-dump: rst_n=0 at beat 12, then released. Required: all outputs 0, no done pulse, IDLE until next start; next dump starts at index 0.
REQ-034 Parameters FIRST_REG=5, LAST_REG=5. Required: one beat, index 5, outLast=1, done one cycle later.
